// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, display enable, raw pixel coordinates and
// line/frame/game-tick strobes. Define VGA_GAME_TICK_EN to include the game-tick divider.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int TICK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          game_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    if ((2 ** CW) <= H_TOTAL) begin : g_bad_h
        $error("vga_timing_gen: CW too small for H_TOTAL");
    end
    if ((2 ** CW) <= V_TOTAL) begin : g_bad_v
        $error("vga_timing_gen: CW too small for V_TOTAL");
    end

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] x_nx, y_nx;
    logic          x_wrap, y_wrap;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

    // All outputs are computed from the next coordinate so they register with it.
    always_comb begin
        x_wrap        = (x_q == H_LAST);
        y_wrap        = (y_q == V_LAST);
        x_nx          = x_wrap ? '0 : x_q + 1'b1;
        y_nx          = x_wrap ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            x_d           = x_nx;
            y_d           = y_nx;
            hsync_d       = ((x_nx >= HS_START) && (x_nx < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d       = ((y_nx >= VS_START) && (y_nx < VS_END)) ? VS_POL : ~VS_POL;
            de_d          = (x_nx < H_ACT) && (y_nx < V_ACT);
            line_start_d  = x_wrap;
            frame_start_d = x_wrap && y_wrap;
        end
    end

    // Reset parks the raster on the last blanking pixel so the first enable lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_GAME_TICK_EN
    if (TICK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: TICK_DIV must be at least 1");
    end

    localparam int            FW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [FW-1:0] FLAST = FW'(TICK_DIV - 1);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          game_tick_q, game_tick_d;

    always_comb begin
        fcnt_d      = fcnt_q;
        game_tick_d = 1'b0;
        if (frame_start_d) begin
            if (fcnt_q == FLAST) begin
                fcnt_d      = '0;
                game_tick_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q      <= FLAST;
            game_tick_q <= 1'b0;
        end else begin
            fcnt_q      <= fcnt_d;
            game_tick_q <= game_tick_d;
        end
    end

    assign game_tick = game_tick_q;
`else
    assign game_tick = 1'b0;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 and 800x600 instances for line timing,
// plus a tiny-raster instance (15x8, TICK_DIV=3) checked every cycle for vertical/tick/gating.
module tb_vga_timing_gen;

`ifdef VGA_GAME_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_ce = 1'b0;

    always #5 clk = ~clk;

    logic [9:0]  d_x, d_y;
    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_gt;
    logic [10:0] s_x, s_y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs, s_gt;
    logic [4:0]  m_x, m_y;
    logic        m_hs, m_vs, m_de, m_ls, m_fs, m_gt;

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .game_tick(d_gt)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11), .TICK_DIV(2)
    ) u_svga (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .game_tick(s_gt)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .TICK_DIV(3)
    ) u_mini (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .hsync(m_hs), .vsync(m_vs), .de(m_de), .x(m_x), .y(m_y),
        .line_start(m_ls), .frame_start(m_fs), .game_tick(m_gt)
    );

    int vectors = 0;
    int miscompares = 0;
    int t = -1;          // enabled pixels since reset release; -1 = reset position
    bit last_ce = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tiny raster: H_TOTAL 15 (hsync low x=10..12), V_TOTAL 8 (vsync low y=5..6), 120 px/frame.
    function automatic logic [15:0] mini_exp(input int tt, input bit ce);
        int  ex, ey;
        bit  hs, vs, de, ls, fs, gt;
        if (tt < 0) return {5'd14, 5'd7, 6'b110000};
        ex = tt % 15;
        ey = (tt / 15) % 8;
        hs = !(ex >= 10 && ex < 13);
        vs = !(ey >= 5 && ey < 7);
        de = (ex < 8) && (ey < 4);
        ls = ce && (ex == 0);
        fs = ls && (ey == 0);
        gt = TICK_EN && fs && (((tt / 120) % 3) == 0);
        return {5'(ex), 5'(ey), hs, vs, de, ls, fs, gt};
    endfunction

    task automatic check_mini();
        chk($sformatf("mini t=%0d", t), {16'd0, m_x, m_y, m_hs, m_vs, m_de, m_ls, m_fs, m_gt},
            {16'd0, mini_exp(t, last_ce)});
    endtask

    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        #1;
        if (ce) t++;
        last_ce = ce;
        check_mini();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " dflt xy"}, {12'd0, d_x, d_y}, {12'd0, 10'd799, 10'd524});
        chk({tag, " dflt ctl"}, {26'd0, d_hs, d_vs, d_de, d_ls, d_fs, d_gt}, 32'b110000);
        chk({tag, " svga xy"}, {10'd0, s_x, s_y}, {10'd0, 11'd1055, 11'd627});
        chk({tag, " svga ctl"}, {26'd0, s_hs, s_vs, s_de, s_ls, s_fs, s_gt}, 32'b000000);
        check_mini();
    endtask

    task automatic first_pixel_checks(input string tag);
        chk({tag, " dflt"}, {6'd0, d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs, d_gt},
            {6'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, TICK_EN});
        chk({tag, " svga"}, {4'd0, s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_gt},
            {4'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, TICK_EN});
    endtask

    int d_hs_n = 0, d_hs_first = -1, d_hs_last = -1, d_de_fall = -1, d_ls2 = -1;
    int s_hs_n = 0, s_hs_first = -1, s_hs_last = -1, s_de_fall = -1, s_ls2 = -1;
    int c1 = -1, c2 = -1, d_ls_double = 0, d_ls_idle = 0;
    bit prev_ls = 1'b0;

    initial begin
        // Reset held from time 0; outputs park on the last blanking pixel.
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        #1;
        reset_checks("rel");

        // Continuous enable: two full 800x600 lines, many tiny frames.
        for (int i = 0; i < 2122; i++) begin
            step(1'b1);
            if (t == 0) first_pixel_checks("first");
            if (t < 800) begin
                if (!d_hs) begin
                    d_hs_n++;
                    if (d_hs_first < 0) d_hs_first = t;
                    d_hs_last = t;
                end
                if (!d_de && d_de_fall < 0) d_de_fall = int'(d_x);
            end
            if (t < 1056) begin
                if (s_hs) begin
                    s_hs_n++;
                    if (s_hs_first < 0) s_hs_first = t;
                    s_hs_last = t;
                end
                if (!s_de && s_de_fall < 0) s_de_fall = int'(s_x);
            end
            if (t > 0 && d_ls && d_ls2 < 0) d_ls2 = t;
            if (t > 0 && s_ls && s_ls2 < 0) s_ls2 = t;
        end
        chk("dflt hsync first x", d_hs_first, 656);
        chk("dflt hsync last x", d_hs_last, 751);
        chk("dflt hsync width", d_hs_n, 96);
        chk("dflt de fall x", d_de_fall, 640);
        chk("dflt line period", d_ls2, 800);
        chk("svga hsync first x", s_hs_first, 840);
        chk("svga hsync last x", s_hs_last, 967);
        chk("svga hsync width", s_hs_n, 128);
        chk("svga de fall x", s_de_fall, 800);
        chk("svga line period", s_ls2, 1056);

        // Enable toggling 1,0: line period doubles, strobes stay one clock wide.
        for (int i = 0; i < 3400; i++) begin
            step((i % 2) == 0);
            if (d_ls) begin
                if (prev_ls) d_ls_double++;
                if (!last_ce) d_ls_idle++;
                if (c1 < 0) c1 = i;
                else if (c2 < 0) c2 = i;
            end
            prev_ls = d_ls;
        end
        chk("gated line period", c2 - c1, 1600);
        chk("gated ls double", d_ls_double, 0);
        chk("gated ls on idle", d_ls_idle, 0);

        // Asynchronous reset mid-frame, observed before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        t = -1;
        last_ce = 1'b0;
        reset_checks("async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1);
        first_pixel_checks("refirst");
        step(1'b0);
        step(1'b0);
        chk("hold after strobe", {12'd0, d_x, d_y}, 32'd0);
        chk("strobes cleared", {29'd0, d_ls, d_fs, d_gt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
